// File: rtl/seg7_scan_decoder.sv
// rtl/seg7_scan_decoder.sv - seven-segment display bus readback decoder
//
// Watches a multiplexed, active-low seven-segment bus and recovers the hex
// digit shown on each position. Every strobe (segment pattern plus digit
// enable) must be seen unchanged for STABLE_CYCLES consecutive clocks before
// it is committed. Illegal segment patterns are flagged per digit.
//
// Ports
//   clk         in   1          rising-edge clock
//   rst_n       in   1          asynchronous active-low reset
//   seg_n       in   7          active-low segments, bit0=a .. bit6=g
//   an_n        in   DIGITS     active-low digit enables
//   value       out  4*DIGITS   decoded nibbles, digit i at [4i+3:4i]
//   valid       out  1          all digits committed legally, no error pending
//   digit_err   out  DIGITS     last commit of digit i was an illegal pattern
//   frame_done  out  1          one-cycle pulse after a commit of digit DIGITS-1

module seg7_scan_decoder #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg_n,
  input  logic [DIGITS-1:0]     an_n,
  output logic [4*DIGITS-1:0]   value,
  output logic                  valid,
  output logic [DIGITS-1:0]     digit_err,
  output logic                  frame_done
);

  localparam int SW = 7 + DIGITS;
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SETTLE    = 2'd1,
    COMMITTED = 2'd2
  } state_t;

  // Returns {legal, nibble}; anything not in the table is illegal.
  function automatic logic [4:0] decode_seg(input logic [6:0] code);
    logic [4:0] r;
    r = 5'h00;
    case (code)
      7'h40: r = 5'h10;
      7'h79: r = 5'h11;
      7'h24: r = 5'h12;
      7'h30: r = 5'h13;
      7'h19: r = 5'h14;
      7'h12: r = 5'h15;
      7'h02: r = 5'h16;
      7'h78: r = 5'h17;
      7'h00: r = 5'h18;
      7'h18: r = 5'h19;
      7'h08: r = 5'h1A;
      7'h03: r = 5'h1B;
      7'h46: r = 5'h1C;
      7'h21: r = 5'h1D;
      7'h06: r = 5'h1E;
      7'h0E: r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  // ------------------------------------------------------------------
  // Input synchronizer; reset to all-ones so nothing looks selected.
  // ------------------------------------------------------------------
  logic [SW-1:0] sync1;
  logic [SW-1:0] sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= {seg_n, an_n};
      sync2 <= sync1;
    end
  end

  logic [6:0]        s2_seg;
  logic [DIGITS-1:0] s2_sel;
  logic              one_hot;

  assign s2_seg  = sync2[SW-1:DIGITS];
  assign s2_sel  = ~sync2[DIGITS-1:0];
  // Exactly one enable low: non-zero and a power of two.
  assign one_hot = (s2_sel != '0) && ((s2_sel & (s2_sel - DIGITS'(1))) == '0);

  // ------------------------------------------------------------------
  // Strobe-stability FSM
  // ------------------------------------------------------------------
  state_t        state;
  state_t        state_nxt;
  logic [SW-1:0] snapshot;
  logic [SW-1:0] snapshot_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          commit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      snapshot <= '1;
      cnt      <= '0;
    end else begin
      state    <= state_nxt;
      snapshot <= snapshot_nxt;
      cnt      <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    snapshot_nxt = snapshot;
    cnt_nxt      = cnt;
    commit       = 1'b0;

    if (!one_hot) begin
      // Tracking the blank/ambiguous pattern guarantees the next real strobe
      // differs from the snapshot, so a re-strobe of the same digit after a
      // gap is re-checked.
      state_nxt    = IDLE;
      snapshot_nxt = sync2;
      cnt_nxt      = '0;
    end else if (sync2 != snapshot) begin
      state_nxt    = SETTLE;
      snapshot_nxt = sync2;
      cnt_nxt      = CNT_ONE;
      // With a single required sample the first sighting is the commit.
      if (CNT_ONE == CNT_MAX) begin
        commit    = 1'b1;
        state_nxt = COMMITTED;
      end
    end else if (state == SETTLE) begin
      if (cnt < CNT_MAX) begin
        cnt_nxt = cnt + CNT_ONE;
      end
      if (cnt_nxt == CNT_MAX) begin
        commit    = 1'b1;
        state_nxt = COMMITTED;
      end
    end
  end

  // ------------------------------------------------------------------
  // Commit datapath
  // ------------------------------------------------------------------
  logic [4:0]          dec;
  logic [4*DIGITS-1:0] value_nxt;
  logic [DIGITS-1:0]   err_nxt;
  logic [DIGITS-1:0]   seen;
  logic [DIGITS-1:0]   seen_nxt;
  logic                frame_nxt;

  // On a commit edge sync2 equals the pattern being committed.
  assign dec = decode_seg(s2_seg);

  always_comb begin
    value_nxt = value;
    err_nxt   = digit_err;
    seen_nxt  = seen;
    frame_nxt = 1'b0;
    if (commit) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (s2_sel[i]) begin
          if (dec[4]) begin
            value_nxt[4*i +: 4] = dec[3:0];
            err_nxt[i]          = 1'b0;
            seen_nxt[i]         = 1'b1;
          end else begin
            err_nxt[i]          = 1'b1;
          end
        end
      end
      frame_nxt = s2_sel[DIGITS-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value      <= '0;
      digit_err  <= '0;
      seen       <= '0;
      valid      <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      value      <= value_nxt;
      digit_err  <= err_nxt;
      seen       <= seen_nxt;
      valid      <= (&seen_nxt) & ~(|err_nxt);
      frame_done <= frame_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb/tb_seg7_scan_decoder.sv - scoreboard bench for seg7_scan_decoder

module tb_seg7_scan_decoder;

  localparam int DIGITS = 4;
  localparam int S      = 3;
  localparam logic [6:0] CODES [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  seg_n = 7'h7F;
  logic [3:0]  an_n = 4'hF;
  logic [15:0] value;
  logic        valid;
  logic [3:0]  digit_err;
  logic        frame_done;

  seg7_scan_decoder #(.DIGITS(DIGITS), .STABLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .seg_n(seg_n), .an_n(an_n),
    .value(value), .valid(valid), .digit_err(digit_err), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          edge_no;
    logic [15:0] value;
    logic        valid;
    logic [3:0]  err;
    logic        fd;
  } exp_t;

  exp_t sb[$];

  logic [3:0]  m_nib [4];
  logic [3:0]  m_err;
  logic [3:0]  m_seen;
  logic [10:0] run_pat;
  int          run_len;
  bit          run_live;
  int          exp_fd_count = 0;
  int          act_fd_count = 0;

  logic [15:0] e_value = '0;
  logic        e_valid = 1'b0;
  logic [3:0]  e_err = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, expv, cyc);
    end
  endtask

  function automatic int decode(input logic [6:0] c);
    for (int i = 0; i < 16; i++) if (CODES[i] == c) return i;
    return -1;
  endfunction

  // A maximal run of identical inputs with one digit selected commits once,
  // S edges after it reaches the DUT pins plus the two synchronizer stages.
  task automatic model_step(input logic [10:0] pat, input int e);
    int   d;
    int   idx;
    exp_t x;
    if (!run_live || pat != run_pat) begin
      run_live = 1'b1;
      run_pat  = pat;
      run_len  = 1;
    end else begin
      run_len++;
    end
    if (run_len == S && $countones(~pat[3:0]) == 1) begin
      idx = 0;
      for (int k = 0; k < 4; k++) if (!pat[k]) idx = k;
      d = decode(pat[10:4]);
      if (d >= 0) begin
        m_nib[idx]  = 4'(d);
        m_err[idx]  = 1'b0;
        m_seen[idx] = 1'b1;
      end else begin
        m_err[idx]  = 1'b1;
      end
      x.edge_no = e + 2;
      for (int k = 0; k < 4; k++) x.value[4*k +: 4] = m_nib[k];
      x.valid = (m_seen == 4'hF) && (m_err == 4'h0);
      x.err   = m_err;
      x.fd    = (idx == 3);
      if (x.fd) exp_fd_count++;
      sb.push_back(x);
    end
  endtask

  task automatic model_reset();
    foreach (sb[i]) if (sb[i].fd) exp_fd_count--;
    sb.delete();
    for (int k = 0; k < 4; k++) m_nib[k] = '0;
    m_err    = '0;
    m_seen   = '0;
    run_live = 1'b0;
    run_len  = 0;
    e_value  = '0;
    e_valid  = 1'b0;
    e_err    = '0;
  endtask

  // Called at a falling edge; returns at a falling edge.
  task automatic apply(input logic [6:0] s, input logic [3:0] a, input int n);
    repeat (n) begin
      seg_n = s;
      an_n  = a;
      model_step({s, a}, cyc + 1);
      @(negedge clk);
    end
  endtask

  task automatic do_reset(input int n, input bit rand_in);
    rst_n = 1'b0;
    model_reset();
    repeat (n) begin
      if (rand_in) begin
        seg_n = 7'($urandom);
        an_n  = 4'($urandom);
      end
      #1;
      check("reset_value", 32'(value), 32'h0);
      check("reset_valid", 32'(valid), 32'h0);
      check("reset_err", 32'(digit_err), 32'h0);
      check("reset_frame_done", 32'(frame_done), 32'h0);
      @(negedge clk);
    end
    seg_n = 7'h7F;
    an_n  = 4'hF;
    rst_n = 1'b1;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() > 0 && guard < 40) begin
      apply(7'h7F, 4'hF, 1);
      guard++;
    end
    apply(7'h7F, 4'hF, 1);
    if (sb.size() > 0) check("drain_timeout", 32'(sb.size()), 32'h0);
  endtask

  task automatic scan_frame();
    apply(7'h0E, 4'b1110, 6);
    apply(7'h18, 4'b1101, 6);
    apply(7'h08, 4'b1011, 6);
    apply(7'h79, 4'b0111, 6);
  endtask

  // Monitor: pops the expectation on its commit edge, otherwise demands that
  // the outputs hold the last committed state with no frame pulse.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        if (frame_done) act_fd_count++;
        if (sb.size() > 0 && sb[0].edge_no <= cyc) begin
          x = sb.pop_front();
          check("commit_edge", 32'(cyc), 32'(x.edge_no));
          e_value = x.value;
          e_valid = x.valid;
          e_err   = x.err;
          check("commit_value", 32'(value), 32'(e_value));
          check("commit_valid", 32'(valid), 32'(e_valid));
          check("commit_err", 32'(digit_err), 32'(e_err));
          check("commit_frame_done", 32'(frame_done), 32'(x.fd));
        end else begin
          check("hold_state", 32'({value, valid, digit_err, frame_done}),
                32'({e_value, e_valid, e_err, 1'b0}));
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout cycle=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] a;
    logic [6:0] s;
    @(negedge clk);
    model_reset();

    // 1: reset with random bus activity
    do_reset(6, 1'b1);
    apply(7'h7F, 4'hF, 3);

    // 2: two full scans of F,A,9,1
    scan_frame();
    drain();
    check("scan_value", 32'(value), 32'h1A9F);
    check("scan_valid", 32'(valid), 32'h1);
    scan_frame();
    drain();
    check("scan2_value", 32'(value), 32'h1A9F);

    // 3: too-short pattern must not commit
    apply(7'h40, 4'b1110, 2);
    apply(7'h79, 4'b1110, 6);
    drain();
    check("short_nibble0", 32'(value[3:0]), 32'h1);

    // 4: illegal then legal on digit 2
    apply(7'h7F, 4'b1011, 6);
    drain();
    check("illegal_err2", 32'(digit_err[2]), 32'h1);
    check("illegal_nibble2", 32'(value[11:8]), 32'hA);
    check("illegal_valid", 32'(valid), 32'h0);
    apply(7'h40, 4'b1011, 6);
    drain();
    check("recover_err2", 32'(digit_err[2]), 32'h0);
    check("recover_nibble2", 32'(value[11:8]), 32'h0);
    check("recover_valid", 32'(valid), 32'h1);

    // 5: no digit / two digits selected
    apply(7'h40, 4'b1111, 10);
    apply(7'h40, 4'b1100, 10);
    drain();
    check("idle_value", 32'(value), 32'h1091);
    check("idle_valid", 32'(valid), 32'h1);

    // 6: reset in the middle of settling
    scan_frame();
    drain();
    apply(7'h24, 4'b1110, 3);
    do_reset(2, 1'b0);
    apply(7'h7F, 4'hF, 2);
    apply(7'h0E, 4'b1110, 6);
    apply(7'h18, 4'b1101, 6);
    apply(7'h08, 4'b1011, 6);
    drain();
    check("post_reset_partial_valid", 32'(valid), 32'h0);
    check("post_reset_partial_value", 32'(value), 32'h0A9F);
    apply(7'h79, 4'b0111, 6);
    drain();
    check("post_reset_full_valid", 32'(valid), 32'h1);
    check("post_reset_full_value", 32'(value), 32'h1A9F);

    // 7: random strobes
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        0:       a = 4'hF;
        1:       a = 4'($urandom);
        default: a = ~(4'b0001 << $urandom_range(0, 3));
      endcase
      if ($urandom_range(0, 3) == 0) s = 7'($urandom);
      else s = CODES[$urandom_range(0, 15)];
      apply(s, a, $urandom_range(1, 6));
    end
    drain();
    check("frame_done_count", 32'(act_fd_count), 32'(exp_fd_count));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
